// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 average-pooling sequencer.
package pool_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_AVG,
    ST_EMIT,
    ST_DONE
  } state_t;

  // 0.25 in IEEE fp16; turns the 4-way sum into the mean
  localparam logic [15:0] FP16_QUARTER = 16'h3400;

  // Pooled-map dimensions for a non-overlapping 2x2 window
  function automatic int out_w(input int in_w);
    return in_w / 2;
  endfunction

  function automatic int out_h(input int in_h);
    return in_h / 2;
  endfunction

endpackage

// File: rtl/avg4_fp16.sv
// Purely combinational fp16 mean of four operands: (((a+b)+c)+d) * 0.25.
// Each add and the final multiply round to nearest-even; subnormals, inf
// and NaN follow IEEE semantics (NaN results are the canonical 16'h7E00).
module avg4_fp16
  import pool_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [15:0] avg
);

  // Round and pack. m[13] is the hidden bit, m[12:3] the fraction, and
  // m[2:0] guard/round/sticky. e is a biased exponent >= 1; a clear hidden
  // bit at e == 1 encodes a subnormal.
  function automatic logic [15:0] fp16_pack(input logic s, input int e,
                                            input logic [13:0] m);
    logic        up;
    logic [11:0] rm;
    int          ex;
    up = m[2] & (m[3] | m[1] | m[0]);
    rm = {1'b0, m[13:3]} + 12'(up);
    ex = e;
    if (rm[11]) begin
      rm = rm >> 1;
      ex = ex + 1;
    end
    if (ex >= 31) return {s, 5'h1F, 10'h000};
    if (!rm[10])  return {s, 5'h00, rm[9:0]};
    return {s, ex[4:0], rm[9:0]};
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] p, input logic [15:0] q);
    logic [15:0] x, y;
    logic [13:0] mx, my, m;
    logic [14:0] sum;
    logic        st;
    int          ex, ey, dd, e;
    if (&p[14:10] || &q[14:10]) begin
      if ((&p[14:10] && |p[9:0]) || (&q[14:10] && |q[9:0])) return 16'h7E00;
      if (&p[14:10] && &q[14:10] && (p[15] != q[15]))       return 16'h7E00;
      return (&p[14:10]) ? p : q;
    end
    // Larger magnitude first so the aligned difference is never negative
    if (p[14:0] >= q[14:0]) begin
      x = p;
      y = q;
    end else begin
      x = q;
      y = p;
    end
    ex = (x[14:10] == 5'd0) ? 1 : int'(x[14:10]);
    ey = (y[14:10] == 5'd0) ? 1 : int'(y[14:10]);
    mx = {|x[14:10], x[9:0], 3'b000};
    my = {|y[14:10], y[9:0], 3'b000};
    dd = ex - ey;
    if (dd >= 14) begin
      st = |my;
      my = '0;
    end else begin
      st = |(my & ((14'h1 << dd) - 14'h1));
      my = my >> dd;
    end
    my[0] = my[0] | st;
    e = ex;
    if (x[15] == y[15]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[14]) begin
        m = sum[14:1] | {13'b0, sum[0]};
        e = e + 1;
      end else begin
        m = sum[13:0];
      end
    end else begin
      m = mx - my;
      if (m == '0) return 16'h0000;
      for (int i = 0; i < 13; i++) begin
        if (!m[13] && e > 1) begin
          m = m << 1;
          e = e - 1;
        end
      end
    end
    return fp16_pack(x[15], e, m);
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] p, input logic [15:0] q);
    logic        s, st;
    logic        p_nan, q_nan, p_inf, q_inf, p_zero, q_zero;
    logic [10:0] mp, mq;
    logic [21:0] prod;
    logic [13:0] m;
    int          ep, eq, e, sh;
    s      = p[15] ^ q[15];
    p_nan  = &p[14:10] && |p[9:0];
    q_nan  = &q[14:10] && |q[9:0];
    p_inf  = &p[14:10] && !(|p[9:0]);
    q_inf  = &q[14:10] && !(|q[9:0]);
    p_zero = (p[14:0] == 15'd0);
    q_zero = (q[14:0] == 15'd0);
    if (p_nan || q_nan || (p_inf && q_zero) || (q_inf && p_zero)) return 16'h7E00;
    if (p_inf || q_inf)   return {s, 5'h1F, 10'h000};
    if (p_zero || q_zero) return {s, 15'h0000};
    mp = {|p[14:10], p[9:0]};
    mq = {|q[14:10], q[9:0]};
    ep = (p[14:10] == 5'd0) ? 1 : int'(p[14:10]);
    eq = (q[14:10] == 5'd0) ? 1 : int'(q[14:10]);
    // Bring subnormal operands up to a leading one
    for (int i = 0; i < 10; i++) begin
      if (!mp[10]) begin
        mp = mp << 1;
        ep = ep - 1;
      end
      if (!mq[10]) begin
        mq = mq << 1;
        eq = eq - 1;
      end
    end
    prod = 22'(mp) * 22'(mq);
    e    = ep + eq - 15;
    if (prod[21]) e = e + 1;
    else          prod = prod << 1;
    m = {prod[21:9], |prod[8:0]};
    if (e < 1) begin
      sh = 1 - e;
      if (sh >= 14) begin
        m = {13'b0, |m};
      end else begin
        st = |(m & ((14'h1 << sh) - 14'h1));
        m  = (m >> sh) | {13'b0, st};
      end
      e = 1;
    end
    return fp16_pack(s, e, m);
  endfunction

  logic [15:0] sum_ab, sum_abc, sum_abcd;

  assign sum_ab   = fp16_add(a, b);
  assign sum_abc  = fp16_add(sum_ab, c);
  assign sum_abcd = fp16_add(sum_abc, d);
  assign avg      = fp16_mul(sum_abcd, FP16_QUARTER);

endmodule

// File: rtl/avg_pool_sequencer.sv
// Walks non-overlapping 2x2 windows of an IN_W x IN_H fp16 map in raster
// order, fetches each window from a single-port buffer, averages it on one
// shared combinational datapath and emits result + pooled address over
// valid/ready.
// Optional build macro: POOL_RELU_EN clamps negative averages (sign bit set,
// including -0) to 16'h0000 with no change in timing.
module avg_pool_sequencer
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_W       = 28,
  parameter int IN_H       = 28,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  localparam int OUT_W = out_w(IN_W);
  localparam int OUT_H = out_h(IN_H);
  localparam logic [ADDR_WIDTH-1:0] LAST_C   = ADDR_WIDTH'(OUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_R   = ADDR_WIDTH'(OUT_H - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IN_W);
  // From the last window of a row pair to the first of the next pair
  localparam logic [ADDR_WIDTH-1:0] WRAP_STEP = ADDR_WIDTH'(IN_W + 2);

  if ((IN_W % 2) != 0 || (IN_H % 2) != 0) begin : g_bad_dims
    $error("avg_pool_sequencer: IN_W and IN_H must be even");
  end
  if ((64'd1 << ADDR_WIDTH) < 64'(IN_W * IN_H)) begin : g_bad_addr
    $error("avg_pool_sequencer: ADDR_WIDTH too small for IN_W*IN_H");
  end
  if (DATA_WIDTH != 16) begin : g_bad_data
    $error("avg_pool_sequencer: DATA_WIDTH must be 16 (fp16)");
  end

  state_t                  state, state_nxt;
  logic [1:0]              idx;
  logic [ADDR_WIDTH-1:0]   row, col, base, win_cnt;
  logic [DATA_WIDTH-1:0]   px [4];
  logic [DATA_WIDTH-1:0]   avg_raw, avg_res;
  logic                    last_win, accept, cap_en;
  logic [1:0]              cap_sel;

  assign last_win = (row == LAST_R) && (col == LAST_C);
  assign accept   = (state == ST_EMIT) && out_ready;

  // Read data lands one cycle after its address, so pixel idx-1 is captured
  // on READ cycles 1..3; in WAIT idx has wrapped to 0 and idx-1 selects 3.
  assign cap_en  = ((state == ST_READ) && (idx != 2'd0)) || (state == ST_WAIT);
  assign cap_sel = idx - 2'd1;

  avg4_fp16 u_avg4 (
    .a   (px[0]),
    .b   (px[1]),
    .c   (px[2]),
    .d   (px[3]),
    .avg (avg_raw)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: flops use <= so every register samples pre-edge values, independent of block order.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned and infers a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_READ;
      ST_READ: if (idx == 2'd3) state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_AVG;
      ST_AVG:  state_nxt = ST_EMIT;
      ST_EMIT: if (out_ready) state_nxt = last_win ? ST_DONE : ST_READ;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs and the buffer address for the current tap
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    rd_en     = (state == ST_READ);
    out_valid = (state == ST_EMIT);
    rd_addr   = '0;
    if (rd_en) rd_addr = base + (idx[1] ? ROW_STEP : '0) + ADDR_WIDTH'(idx[0]);
  end

  // Optional clamp of negative averages before they are registered
  always_comb begin
`ifdef POOL_RELU_EN
    avg_res = avg_raw[DATA_WIDTH-1] ? '0 : avg_raw;
`else
    avg_res = avg_raw;
`endif
  end

  // Window counters, pixel capture and the registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      row      <= '0;
      col      <= '0;
      base     <= '0;
      win_cnt  <= '0;
      out_data <= '0;
      out_addr <= '0;
      // NOTE: the four pixel registers are plain flops, not a RAM, so they are cleared on reset too.
      for (int i = 0; i < 4; i++) px[i] <= '0;
    end else begin
      if (state == ST_READ) idx <= idx + 2'd1;
      if (cap_en) px[cap_sel] <= rd_data;
      if (state == ST_AVG) begin
        out_data <= avg_res;
        out_addr <= win_cnt;
      end
      if (accept && !last_win) begin
        win_cnt <= win_cnt + ADDR_WIDTH'(1);
        if (col == LAST_C) begin
          col  <= '0;
          row  <= row + ADDR_WIDTH'(1);
          base <= base + WRAP_STEP;
        end else begin
          col  <= col + ADDR_WIDTH'(1);
          base <= base + ADDR_WIDTH'(2);
        end
      end
      if (state == ST_DONE) begin
        idx     <= '0;
        row     <= '0;
        col     <= '0;
        base    <= '0;
        win_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_sequencer.sv
// Bench for avg_pool_sequencer on a 4x4 map with a behavioural input buffer
// and a real-arithmetic fp16 reference for the pooled values.
module tb_avg_pool_sequencer;

  localparam int IN_W = 4;
  localparam int IN_H = 4;
  localparam int AW   = 4;
  localparam int NPIX = IN_W * IN_H;
  localparam int NWIN = NPIX / 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, rd_en, out_valid;
  logic [AW-1:0] rd_addr, out_addr;
  logic [15:0]   rd_data = '0;
  logic [15:0]   out_data;
  logic [15:0]   mem [NPIX];

  int tests = 0;
  int fails = 0;

  logic [15:0] od_q [$];
  int          oa_q [$];
  int          ra_q [$];
  int done_cnt, done_cyc, first_valid, first_acc, gap_err, rd_in_emit, stall_err;
  bit finished;

  avg_pool_sequencer #(
    .DATA_WIDTH (16),
    .IN_W       (IN_W),
    .IN_H       (IN_H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  always #5 clk = ~clk;

  // Single-port input buffer: data valid the cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    v = (e == 0) ? real'(h[9:0]) / 1024.0 : 1.0 + real'(h[9:0]) / 1024.0;
    if (e == 0) e = 1;
    for (int i = 15; i < e; i++) v = v * 2.0;
    for (int i = e; i < 15; i++) v = v / 2.0;
    return h[15] ? -v : v;
  endfunction

  // Round a real to the nearest-even fp16 (normal range is enough here)
  function automatic logic [15:0] r2h(input real v);
    logic s;
    real  a, fr, rem;
    int   e, f;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    fr  = (a - 1.0) * 1024.0;
    f   = $rtoi(fr);
    rem = fr - real'(f);
    if (rem > 0.5 || (rem == 0.5 && (f % 2) == 1)) f++;
    if (f == 1024) begin f = 0; e++; end
    return {s, 5'(e + 15), 10'(f)};
  endfunction

  function automatic logic [15:0] model_avg(input int w);
    int          b;
    logic [15:0] s, q;
    b = (w / (IN_W / 2)) * 2 * IN_W + (w % (IN_W / 2)) * 2;
    s = r2h(h2r(mem[b]) + h2r(mem[b + 1]));
    s = r2h(h2r(s) + h2r(mem[b + IN_W]));
    s = r2h(h2r(s) + h2r(mem[b + IN_W + 1]));
    q = r2h(h2r(s) * 0.25);
`ifdef POOL_RELU_EN
    if (q[15]) q = 16'h0000;
`endif
    return q;
  endfunction

  function automatic logic [15:0] rand_pix();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(15, 21)), 10'($urandom)};
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) mem[i] = rand_pix();
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < NPIX; i++) mem[i] = v;
  endtask

  // mode 0: ready high; 1: random ready; 2: first EMIT stalled 5 cycles;
  // 3: random ready with start pulsed while busy
  task automatic run_pass(input int mode);
    int          last_acc, s_cnt;
    logic [15:0] hold_d;
    logic [AW-1:0] hold_a;
    od_q.delete(); oa_q.delete(); ra_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; first_acc = -1;
    gap_err = 0; rd_in_emit = 0; stall_err = 0; finished = 0;
    last_acc = -100; s_cnt = 0; hold_d = '0; hold_a = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (last_acc == k - 1 && !(rd_en || done)) gap_err++;
      if (rd_en) ra_q.push_back(int'(rd_addr));
      if (rd_en && out_valid) rd_in_emit++;
      if (done) begin done_cnt++; done_cyc = k; end
      if (out_valid && first_valid < 0) first_valid = k;
      if (mode == 2 && out_valid && od_q.size() == 0) begin
        if (s_cnt == 0) begin
          hold_d = out_data;
          hold_a = out_addr;
        end else if (out_data !== hold_d || out_addr !== hold_a) begin
          stall_err++;
        end
        out_ready = (s_cnt >= 5);
        s_cnt++;
      end else if (mode == 1 || mode == 3) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      start = (mode == 3 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (out_valid && out_ready) begin
        od_q.push_back(out_data);
        oa_q.push_back(int'(out_addr));
        if (first_acc < 0) first_acc = k;
        last_acc = k;
      end
      if (done) begin
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_results(input string tag);
    int exp_rd [$];
    check({tag, " finished"}, 32'(finished), 1);
    check({tag, " n_out"}, od_q.size(), NWIN);
    for (int i = 0; i < od_q.size() && i < NWIN; i++) begin
      check($sformatf("%s out_data[%0d]", tag, i), od_q[i], model_avg(i));
      check($sformatf("%s out_addr[%0d]", tag, i), oa_q[i], i);
    end
    for (int r = 0; r < IN_H / 2; r++)
      for (int c = 0; c < IN_W / 2; c++) begin
        exp_rd.push_back(2 * r * IN_W + 2 * c);
        exp_rd.push_back(2 * r * IN_W + 2 * c + 1);
        exp_rd.push_back(2 * r * IN_W + 2 * c + IN_W);
        exp_rd.push_back(2 * r * IN_W + 2 * c + IN_W + 1);
      end
    check({tag, " n_rd"}, ra_q.size(), exp_rd.size());
    for (int i = 0; i < ra_q.size() && i < exp_rd.size(); i++)
      check($sformatf("%s rd_addr[%0d]", tag, i), ra_q[i], exp_rd[i]);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " read_after_accept"}, gap_err, 0);
    check({tag, " rd_en_in_emit"}, rd_in_emit, 0);
  endtask

  initial begin
    logic [15:0] neg_exp;
    fill_const(16'h0000);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst rd_en", 32'(rd_en), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst rd_addr", 32'(rd_addr), 0);
    check("rst out_addr", 32'(out_addr), 0);
    check("rst out_data", 32'(out_data), 0);
    reset = 1'b0;

    // All ones, ready held high: latency and pass length
    fill_const(16'h3C00);
    run_pass(0);
    check_results("ones");
    check("ones first_valid", first_valid, 7);
    check("ones done_cycle", done_cyc, NWIN * 7 + 1);

    // First window 1,2,3,4 -> 2.5
    fill_random();
    mem[0] = 16'h3C00; mem[1] = 16'h4000; mem[4] = 16'h4200; mem[5] = 16'h4400;
    run_pass(1);
    check_results("1234");
    check("1234 win0", (od_q.size() > 0) ? od_q[0] : 16'hxxxx, 16'h4100);

    // Negative map
    fill_const(16'hBC00);
`ifdef POOL_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hBC00;
`endif
    run_pass(0);
    check_results("neg");
    check("neg win0", (od_q.size() > 0) ? od_q[0] : 16'hxxxx, neg_exp);

    // Five-cycle stall in the first EMIT
    fill_random();
    run_pass(2);
    check_results("stall");
    check("stall hold", stall_err, 0);
    check("stall first_acc", first_acc, 12);

    // Reset during READ idx 2
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid rd_en", 32'(rd_en), 1);
    check("mid rd_addr", 32'(rd_addr), 4);
    reset = 1'b1;
    @(negedge clk);
    check("mid busy", 32'(busy), 0);
    check("mid rd_en_off", 32'(rd_en), 0);
    check("mid out_valid", 32'(out_valid), 0);
    reset = 1'b0;
    fill_random();
    run_pass(0);
    check_results("restart");
    check("restart first_valid", first_valid, 7);

    // start pulsed while busy is ignored
    fill_random();
    run_pass(3);
    check_results("spurious");
    repeat (4) @(negedge clk);
    check("spurious idle", 32'(busy), 0);

    // Random maps under random backpressure
    for (int p = 0; p < 3; p++) begin
      fill_random();
      run_pass(1);
      check_results($sformatf("rand%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avg_pool_sequencer.md
# avg_pool_sequencer

Sequences one shared, combinational fp16 2x2 average datapath over a full input feature map. The block walks non-overlapping 2x2 windows in raster order and fetches four pixels from a single-port input buffer. It registers their average and emits each result with its output-map address over a valid/ready handshake. It sits between the layer buffer that feeds the pooling layer and the writer of the pooled map, and is started once per map by the layer controller.

## Interface
- DATA_WIDTH, 16: pixel width, IEEE fp16.
- IN_W, 28: input map width; must be even.
- IN_H, 28: input map height; must be even.
- ADDR_WIDTH, 10: width of rd_addr and out_addr; must satisfy 2^ADDR_WIDTH >= IN_W*IN_H.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin one map pass; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last window is accepted.
- rd_en  output  1  input buffer read strobe.
- rd_addr  output  ADDR_WIDTH  input buffer address, row-major.
- rd_data  input  DATA_WIDTH  buffer data, valid the cycle after rd_en.
- out_valid  output  1  out_data/out_addr valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_data  output  DATA_WIDTH  pooled pixel.
- out_addr  output  ADDR_WIDTH  output-map index r*(IN_W/2)+c.

## Operation
- FSM states: IDLE, READ, WAIT, AVG, EMIT, DONE.
- IDLE -> READ on start. start at any other time is ignored.
- READ lasts 4 cycles with idx = 0..3. rd_en = 1.
  - rd_addr for idx 0/1/2/3 = base, base+1, base+IN_W, base+IN_W+1, where base = 2r*IN_W + 2c.
- rd_data is captured into pixel register idx-1 on READ cycles 1..3 and on WAIT (idx 3).
- WAIT -> AVG -> EMIT, one cycle each.
  - AVG registers the result ((A+B)+C)+D, multiplied by 16'h3400 (0.25), into out_data.
  - out_addr is updated in the same cycle.
- EMIT: out_valid = 1. out_data and out_addr hold stable until out_valid & out_ready.
  - On acceptance, if the window is not last: advance c, or wrap c to 0 and increment r. Go to READ.
  - On acceptance of the last window (r = IN_H/2-1, c = IN_W/2-1): go to DONE.
- DONE: done = 1 for one cycle, counters cleared, then IDLE.
- out_addr is kept as an incrementing counter, with no multiplier.
- Reset in any state: go to IDLE, clear all counters and pixel registers. Any in-flight window is discarded.
- Reset values of outputs: busy, done, rd_en, out_valid = 0; rd_addr, out_addr, out_data = 0.
- Parameter violations (odd IN_W/IN_H, ADDR_WIDTH too small) fail at elaboration.

## Timing
- start high in IDLE at edge t:
  - rd_en high for cycles t+1..t+4.
  - WAIT at t+5, AVG at t+6.
  - out_valid first high at t+7.
- Throughput: 7 cycles per window with out_ready held high. A full pass of 14x14 windows takes 196*7 + 1 (DONE) cycles.
- Backpressure: each cycle out_ready is low in EMIT adds one cycle. No reads are issued while stalled.
- out_ready high while out_valid is low has no effect.
- Acceptance in cycle k puts the next window's READ idx 0 in cycle k+1.

## Configuration
- POOL_RELU_EN defined: if the AVG result has its sign bit set, out_data is registered as 16'h0000. This covers negatives and -0.
- POOL_RELU_EN undefined: the average passes through unmodified, including negative values and 16'h8000.
- Timing is identical in both builds.

## Structure
- Package pool_pkg holds:
  - the FSM state enum;
  - the constant FP16_QUARTER = 16'h3400;
  - OUT_W/OUT_H derivation functions.
- One sub-module, avg4_fp16: a purely combinational average of four fp16 operands using the team's float adder and multiplier. It is instantiated once and shared across all windows.
- The FSM, counters and pixel/output registers live in avg_pool_sequencer.

## Test plan
- IN_W=IN_H=4, all pixels 16'h3C00, out_ready=1 -> four outputs of 16'h3C00 at out_addr 0,1,2,3. First out_valid at t+7. done 1 cycle after the 4th acceptance.
- Window pixels 1,2,3,4 (16'h3C00, 4000, 4200, 4400) -> out_data 16'h4100 (2.5). rd_addr sequence 0,1,4,5 then 2,3,6,7.
- All pixels 16'hBC00 -> out_data 16'hBC00 without POOL_RELU_EN; 16'h0000 with POOL_RELU_EN.
- out_ready low for 5 cycles in first EMIT -> out_data/out_addr stable, rd_en low throughout. Next READ starts the cycle after acceptance.
- Reset asserted during READ idx 2 -> next cycle busy=0, rd_en=0, out_valid=0. A new start restarts from rd_addr 0, out_addr 0.
- start pulsed while busy -> ignored; exactly IN_W*IN_H/4 outputs and one done pulse.
